even_parity_serial_rx: RTL and testbench
========================================

Name: even_parity_serial_rx

Overview:
Serial receiver and checker for even-parity frames. It is the receiving end of the byte-wide even-parity generator path. A frame on the line is: start bit (0), DATA_W data bits sent LSB first, one even-parity bit, and a stop bit (1). The block deserializes each frame, checks parity and framing, and presents the byte with error flags and a saturating error counter. Bit timing comes from an external one-cycle strobe (bit_en); there is no oversampling inside the block.

Parameters:
DATA_W, 8, number of data bits per frame (1..16).
CNT_W, 8, width of the saturating error counter.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
bit_en  input  1  one-cycle strobe marking the sample point of each serial bit.
rx_in  input  1  serial line, idle high; sampled only when bit_en=1.
data_out  output  DATA_W  last received data word; held until the next frame completes.
data_valid  output  1  one-cycle pulse when a frame completes (good or bad).
parity_err  output  1  last completed frame had an odd count of ones over data plus parity bit.
frame_err  output  1  last completed frame had stop bit sampled as 0.
busy  output  1  high while a frame is in progress (any state other than IDLE).
err_cnt  output  CNT_W  count of completed frames with parity_err or frame_err; saturates at all-ones.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0, err_cnt=0.
  - FSM goes to IDLE; bit counter, shift register and parity accumulator are cleared.
  - Reset takes priority over all other events; a mid-frame reset discards the partial frame with no data_valid pulse.
- FSM states: IDLE, DATA, PARITY, STOP. Transitions happen only on edges where bit_en=1. With bit_en=0 the state and all registers hold, and rx_in is ignored.
- IDLE:
  - bit_en=1 and rx_in=0: go to DATA; clear bit counter and parity accumulator.
  - bit_en=1 and rx_in=1: stay in IDLE.
- DATA:
  - Each bit_en: shift rx_in into the MSB of the shift register (right shift, so the first bit ends up at the LSB); XOR rx_in into the parity accumulator; increment the bit counter.
  - After the DATA_W-th bit go to PARITY.
- PARITY:
  - bit_en: XOR rx_in into the accumulator; go to STOP.
- STOP, on bit_en, all in the same edge:
  - data_out <= shift register.
  - parity_err <= accumulator (1 means odd total = error).
  - frame_err <= ~rx_in.
  - data_valid <= 1.
  - go to IDLE.
- Latency: data_valid is high in the cycle immediately after the clk edge that sampled the stop bit, for exactly one cycle.
- Error flags and data_out update only on frame completion and otherwise hold their value.
- err_cnt increments by 1 in the same edge data_valid is set if (parity_err | frame_err) for that frame. At all-ones it stays at all-ones.
- busy=1 in DATA, PARITY and STOP; busy=0 in IDLE. It is registered from state, with no combinational path from rx_in.
- A failed stop bit does not resync the line. The FSM returns to IDLE and waits for the next sampled 0. A stop-bit 0 therefore does not double as a start bit.
- Back-to-back frames: a start bit on the bit_en immediately after the stop bit is accepted. There are no idle bits between frames.
- Consecutive bit_en pulses on adjacent cycles are legal; the minimum spacing is 1 cycle.

Test Plan:
- Reset, then frame for 0x03: bits 0, 1,1,0,0,0,0,0,0, parity 0, stop 1, with bit_en every 4 cycles. Expect data_out=0x03, data_valid pulse of 1 cycle, parity_err=0, frame_err=0, err_cnt=0; busy high from the start-bit edge until the stop-bit edge.
- Frame for 0x1C with parity 1, then 0x55 with parity 0, back-to-back with bit_en every cycle. Expect two valid pulses with data_out 0x1C then 0x55, no errors, err_cnt=0.
- Frame for 0xDB (6 ones) sent with parity 1. Expect parity_err=1, frame_err=0, data_out=0xDB, err_cnt=1. The next frame, 0x01 with parity 1, clears parity_err to 0 and err_cnt stays 1.
- Frame for 0xF0 with parity 0 and stop bit 0. Expect frame_err=1, parity_err=0, err_cnt increments. The line then held at 1 for 3 bit_en leaves the FSM in IDLE with busy=0.
- Reset asserted after 5 data bits of a frame. Expect busy=0 on the next cycle, no data_valid, all outputs 0. A following full frame for 0xAA (parity 0) is received correctly.
- Force err_cnt to 255 by 255 bad frames, then send one more bad frame. Expect err_cnt stays 255 and data_valid still pulses.

Source files
------------

// File: rtl/even_parity_serial_rx.sv
// Even-parity serial frame receiver: start, DATA_W bits LSB first,
// parity, stop. Bit timing from an external bit_en strobe.
module even_parity_serial_rx #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              rx_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int BC_W = $clog2(DATA_W + 1);

  state_t            state_q, state_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              par_q, par_d;
  logic              dv_q, dv_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic [CNT_W-1:0]  ecnt_q, ecnt_d;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    par_d   = par_q;
    dv_d    = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ecnt_d  = ecnt_q;
    if (bit_en) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_in) begin
            state_d = DATA;
            bcnt_d  = '0;
            par_d   = 1'b0;
          end
        end
        DATA: begin
          // Right shift so the first (LSB) bit lands at bit 0.
          sh_d = sh_q >> 1;
          sh_d[DATA_W-1] = rx_in;
          par_d  = par_q ^ rx_in;
          bcnt_d = bcnt_q + BC_W'(1);
          if (bcnt_q == BC_W'(DATA_W - 1)) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_d   = par_q ^ rx_in;
          state_d = STOP;
        end
        STOP: begin
          dout_d  = sh_q;
          perr_d  = par_q;
          ferr_d  = ~rx_in;
          dv_d    = 1'b1;
          state_d = IDLE;
          if ((par_q | ~rx_in) && (ecnt_q != '1)) begin
            ecnt_d = ecnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      par_q   <= 1'b0;
      dv_q    <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      par_q   <= par_d;
      dv_q    <= dv_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);
  assign err_cnt    = ecnt_q;

endmodule

// File: tb/tb_even_parity_serial_rx.sv
// Bench for even_parity_serial_rx: frame table driven into a
// scoreboard, plus hand-written reset, resync and saturation cases.
module tb_even_parity_serial_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_en;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
  logic [7:0] err_cnt;

  even_parity_serial_rx #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bit_en(bit_en),
    .rx_in(rx_in),
    .data_out(data_out),
    .data_valid(data_valid),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .busy(busy),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_perr;
    logic       exp_ferr;
    int         gap;
  } frame_t;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic       dv_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Starts and ends on a falling edge.
  task automatic send_bit(input logic b, input int gap);
    rx_in  = b;
    bit_en = 1'b1;
    @(negedge clk);
    bit_en = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_frame(input frame_t f);
    exp_t e;
    send_bit(1'b0, f.gap);
    check("busy_after_start", busy, 1);
    for (int i = 0; i < 8; i++) send_bit(f.data[i], f.gap);
    send_bit(f.par, f.gap);
    if ((f.exp_perr || f.exp_ferr) && exp_cnt != 8'hFF)
      exp_cnt = exp_cnt + 8'd1;
    e.data = f.data;
    e.perr = f.exp_perr;
    e.ferr = f.exp_ferr;
    e.cnt  = exp_cnt;
    sb.push_back(e);
    send_bit(f.stop, f.gap);
    check("busy_after_stop", busy, 0);
  endtask

  always @(negedge clk) begin
    if (data_valid) begin
      check("valid_one_cycle", dv_prev, 0);
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_valid: data %0h", data_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("data_out", data_out, e.data);
        check("parity_err", parity_err, e.perr);
        check("frame_err", frame_err, e.ferr);
        check("err_cnt", err_cnt, e.cnt);
      end
    end
    dv_prev = data_valid;
  end

  frame_t tbl[6];

  initial begin
    tbl[0] = '{8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 4};
    tbl[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[2] = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[3] = '{8'hDB, 1'b1, 1'b1, 1'b1, 1'b0, 1};
    tbl[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 2};
    tbl[5] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 1};

    rst    = 1'b1;
    bit_en = 1'b0;
    rx_in  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_data_out", data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) send_frame(tbl[i]);

    // Stop-bit 0 must not act as a start bit; idle ones keep it idle.
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1);
    check("idle_after_ferr", busy, 0);
    check("err_cnt_after_ferr", err_cnt, 2);

    // Mid-frame reset after five data bits.
    send_bit(1'b0, 1);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 8'd0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", data_valid, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_perr", parity_err, 0);
    check("mid_rst_ferr", frame_err, 0);
    check("mid_rst_cnt", err_cnt, 0);
    repeat (3) @(negedge clk);
    send_frame('{8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 1});

    // Saturation: 255 bad-parity frames, then one more.
    for (int i = 0; i < 256; i++)
      send_frame('{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1});
    repeat (3) @(negedge clk);
    check("err_cnt_saturated", err_cnt, 8'hFF);
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
